mem_access: RTL and testbench

Memory-access (MEM) stage of the MIPS core, between the EX/MEM pipeline register and `mem_wb`. It decodes the load/store type, checks alignment, and drives a single-outstanding data-bus transaction. It aligns, extends and merges loaded data, resolves LL/SC against the LLbit, and stalls the pipeline while a transaction is in flight. Outputs feed `mem_wb` directly: `mem_wd`, `mem_wreg`, `mem_wdata`, the LLbit fields and `excepttype`.

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/mem_access_lane_align.sv | 47 ++++
 rtl/mem_access.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: memory op codes, FSM states,
// exception bit positions and op classification functions.
package mem_pkg;

    localparam int ExceptionTypeWidth = 32;

    localparam int EXC_ADEL = 4;
    localparam int EXC_ADES = 5;
    localparam int EXC_DBE  = 7;

    typedef enum logic [3:0] {
        MOP_NONE = 4'd0,
        MOP_LB   = 4'd1,
        MOP_LBU  = 4'd2,
        MOP_LH   = 4'd3,
        MOP_LHU  = 4'd4,
        MOP_LW   = 4'd5,
        MOP_SB   = 4'd6,
        MOP_SH   = 4'd7,
        MOP_SW   = 4'd8,
        MOP_LL   = 4'd9,
        MOP_SC   = 4'd10
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } mem_state_t;

    function automatic logic op_is_store(input mem_op_t op);
        return (op == MOP_SB) || (op == MOP_SH) || (op == MOP_SW) || (op == MOP_SC);
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lo);
        logic bad;
        case (op)
            MOP_LH, MOP_LHU, MOP_SH:        bad = lo[0];
            MOP_LW, MOP_SW, MOP_LL, MOP_SC: bad = (lo != 2'b00);
            default:                        bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Big-endian byte-lane steering: bus byte enables, replicated store data and
// sign/zero-extended load data. Purely combinational so fetch can reuse it.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;

    // Lane selection and per-op steering; addr_lo 00 is the most significant byte
    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel_s = load_word[31:24];
            2'b01:   byte_sel_s = load_word[23:16];
            2'b10:   byte_sel_s = load_word[15:8];
            default: byte_sel_s = load_word[7:0];
        endcase
        half_sel_s  = addr_lo[1] ? load_word[15:0] : load_word[31:16];
        be          = 4'b1111;
        store_wdata = store_data;
        load_data   = load_word;
        case (op)
            MOP_SB: begin
                be          = 4'b1000 >> addr_lo;
                store_wdata = {4{store_data[7:0]}};
            end
            MOP_SH: begin
                be          = addr_lo[1] ? 4'b0011 : 4'b1100;
                store_wdata = {2{store_data[15:0]}};
            end
            MOP_LB:  load_data = {{24{byte_sel_s[7]}}, byte_sel_s};
            MOP_LBU: load_data = {24'd0, byte_sel_s};
            MOP_LH:  load_data = {{16{half_sel_s[15]}}, half_sel_s};
            MOP_LHU: load_data = {16'd0, half_sel_s};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: alignment checks, single-outstanding data-bus access,
// load extension, LL/SC resolution and pipeline stall generation.
module mem_access
    import mem_pkg::*;
#(
    parameter int EXC_W = ExceptionTypeWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ex_mem_op,
    input  logic [31:0]      ex_addr,
    input  logic [31:0]      ex_store_data,
    input  logic [4:0]       ex_wd,
    input  logic             ex_wreg,
    input  logic [31:0]      ex_wdata,
    input  logic [EXC_W-1:0] ex_excepttype,
    input  logic             llbit_i,
    input  logic             flush,
    output logic             dbus_req,
    output logic             dbus_we,
    output logic [31:0]      dbus_addr,
    output logic [3:0]       dbus_be,
    output logic [31:0]      dbus_wdata,
    input  logic             dbus_ack,
    input  logic             dbus_err,
    input  logic [31:0]      dbus_rdata,
    output logic [4:0]       mem_wd,
    output logic             mem_wreg,
    output logic [31:0]      mem_wdata,
    output logic             mem_wreg_LLbit,
    output logic             mem_wdata_LLbit,
    output logic [EXC_W-1:0] mem_excepttype,
    output logic [31:0]      mem_badvaddr,
    output logic             stall_req
);

    mem_state_t       state_r, next_state_s;
    mem_op_t          op_s;
    logic             misalign_s, sc_fail_s, start_s, load_bus_s;
    logic [31:0]      rdata_r;
    logic             err_r;
    logic             bus_we_r;
    logic [31:0]      bus_addr_r, bus_wdata_r;
    logic [3:0]       bus_be_r;
    logic [3:0]       be_s;
    logic [31:0]      store_wdata_s, load_data_s;
    logic             stall_s, wreg_s, wreg_ll_s, wdata_ll_s;
    logic [31:0]      wdata_s, badv_s;
    logic [EXC_W-1:0] local_exc_s;

    assign op_s = mem_op_t'(ex_mem_op);

    mem_lane_align u_lane (
        .op          (op_s),
        .addr_lo     (ex_addr[1:0]),
        .store_data  (ex_store_data),
        .load_word   (rdata_r),
        .be          (be_s),
        .store_wdata (store_wdata_s),
        .load_data   (load_data_s)
    );

    // Op classification: alignment faults take priority over a failed SC
    always_comb begin
        misalign_s = op_misaligned(op_s, ex_addr[1:0]);
        sc_fail_s  = (op_s == MOP_SC) && !llbit_i && !misalign_s;
        start_s    = (op_s != MOP_NONE) && !misalign_s && !sc_fail_s;
    end

    // Next-state and writeback decode
    always_comb begin
        next_state_s = state_r;
        load_bus_s   = 1'b0;
        stall_s      = 1'b0;
        wreg_s       = ex_wreg;
        wdata_s      = ex_wdata;
        wreg_ll_s    = 1'b0;
        wdata_ll_s   = 1'b0;
        local_exc_s  = '0;
        badv_s       = 32'd0;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    wreg_s = 1'b0;
                end else if (misalign_s) begin
                    wreg_s = 1'b0;
                    badv_s = ex_addr;
                    if (op_is_store(op_s)) begin
                        local_exc_s[EXC_ADES] = 1'b1;
                    end else begin
                        local_exc_s[EXC_ADEL] = 1'b1;
                    end
                end else if (sc_fail_s) begin
                    wreg_s  = 1'b1;
                    wdata_s = 32'd0;
                end else if (start_s) begin
                    stall_s      = 1'b1;
                    wreg_s       = 1'b0;
                    load_bus_s   = 1'b1;
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                wreg_s  = 1'b0;
                if (dbus_ack) begin
                    next_state_s = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    next_state_s = ST_ABORT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_ABORT: begin
                stall_s = 1'b1;
                wreg_s  = 1'b0;
                next_state_s = dbus_ack ? ST_IDLE : ST_ABORT;
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
                if (flush) begin
                    wreg_s = 1'b0;
                end else if (err_r) begin
                    wreg_s                = 1'b0;
                    badv_s                = ex_addr;
                    local_exc_s[EXC_DBE]  = 1'b1;
                end else begin
                    case (op_s)
                        MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW: wdata_s = load_data_s;
                        MOP_LL: begin
                            wdata_s    = load_data_s;
                            wreg_ll_s  = 1'b1;
                            wdata_ll_s = 1'b1;
                        end
                        MOP_SC: begin
                            wreg_s     = 1'b1;
                            wdata_s    = 32'd1;
                            wreg_ll_s  = 1'b1;
                            wdata_ll_s = 1'b0;
                        end
                        default: wreg_s = 1'b0;
                    endcase
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bus request fields are latched so an aborted request survives the ex/mem flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'd0;
            bus_wdata_r <= 32'd0;
            rdata_r     <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            if (load_bus_s) begin
                bus_we_r    <= op_is_store(op_s);
                bus_addr_r  <= {ex_addr[31:2], 2'b00};
                bus_be_r    <= be_s;
                bus_wdata_r <= store_wdata_s;
            end
            if ((state_r == ST_REQ) && dbus_ack) begin
                rdata_r <= dbus_rdata;
                err_r   <= dbus_err;
            end
        end
    end

    // Output stage; everything toward the pipeline is forced quiet during reset
    always_comb begin
        dbus_req        = !rst && ((state_r == ST_REQ) || (state_r == ST_ABORT));
        dbus_we         = bus_we_r;
        dbus_addr       = bus_addr_r;
        dbus_be         = bus_be_r;
        dbus_wdata      = bus_wdata_r;
        stall_req       = !rst && stall_s;
        mem_wd          = rst ? 5'd0 : ex_wd;
        mem_wreg        = !rst && wreg_s;
        mem_wdata       = rst ? 32'd0 : wdata_s;
        mem_wreg_LLbit  = !rst && wreg_ll_s;
        mem_wdata_LLbit = !rst && wdata_ll_s;
        mem_excepttype  = rst ? '0 : (ex_excepttype | local_exc_s);
        mem_badvaddr    = rst ? 32'd0 : badv_s;
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: hand-computed expectations checked with
// immediate assertions at the falling clock edge.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ex_mem_op = 4'd0;
    logic [31:0] ex_addr = 32'd0, ex_store_data = 32'd0, ex_wdata = 32'd0;
    logic [4:0]  ex_wd = 5'd0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_excepttype = 32'd0;
    logic        llbit_i = 1'b0, flush = 1'b0;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack = 1'b0, dbus_err = 1'b0;
    logic [31:0] dbus_rdata = 32'd0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_wreg_LLbit, mem_wdata_LLbit, stall_req;
    logic [31:0] mem_wdata, mem_excepttype, mem_badvaddr;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_access #(.EXC_W(32)) dut (
        .clk(clk), .rst(rst), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_wdata(ex_wdata), .ex_excepttype(ex_excepttype), .llbit_i(llbit_i),
        .flush(flush), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
        .dbus_err(dbus_err), .dbus_rdata(dbus_rdata), .mem_wd(mem_wd),
        .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_wreg_LLbit(mem_wreg_LLbit),
        .mem_wdata_LLbit(mem_wdata_LLbit), .mem_excepttype(mem_excepttype),
        .mem_badvaddr(mem_badvaddr), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd);
        ex_mem_op     = op;
        ex_addr       = addr;
        ex_store_data = sdata;
        ex_wd         = wd;
        ex_wreg       = 1'b1;
        ex_wdata      = 32'h0BAD_0BAD;
        ex_excepttype = 32'd0;
    endtask

    task automatic go_idle();
        ex_mem_op = MOP_NONE;
        dbus_ack  = 1'b0;
        dbus_err  = 1'b0;
        flush     = 1'b0;
        llbit_i   = 1'b0;
    endtask

    initial begin
        // Reset with a load pending: everything must stay quiet
        set_op(MOP_LW, 32'h0000_1000, 32'd0, 5'd4);
        @(negedge clk);
        chk("rst_req",   {31'd0, dbus_req},  32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wreg",  {31'd0, mem_wreg},  32'd0);
        chk("rst_wdata", mem_wdata,          32'd0);
        go_idle();
        rst = 1'b0;
        next_cycle();

        // Pass-through
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_excepttype = 32'h1;
        @(negedge clk);
        chk("pt_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("pt_wd",    {27'd0, mem_wd}, 32'd5);
        chk("pt_wreg",  {31'd0, mem_wreg}, 32'd1);
        chk("pt_exc",   mem_excepttype, 32'h1);
        chk("pt_stall", {31'd0, stall_req}, 32'd0);
        next_cycle();

        // LB at 0x1003, ack in second REQ cycle
        set_op(MOP_LB, 32'h0000_1003, 32'd0, 5'd3);
        @(negedge clk);
        chk("lb_c0_stall", {31'd0, stall_req}, 32'd1);
        chk("lb_c0_req",   {31'd0, dbus_req},  32'd0);
        chk("lb_c0_wreg",  {31'd0, mem_wreg},  32'd0);
        next_cycle();
        @(negedge clk);
        chk("lb_c1_req",   {31'd0, dbus_req},  32'd1);
        chk("lb_addr",     dbus_addr,          32'h0000_1000);
        chk("lb_be",       {28'd0, dbus_be},   32'hF);
        chk("lb_we",       {31'd0, dbus_we},   32'd0);
        chk("lb_c1_stall", {31'd0, stall_req}, 32'd1);
        next_cycle();
        dbus_ack = 1'b1; dbus_rdata = 32'h1122_3380;
        @(negedge clk);
        chk("lb_c2_stall", {31'd0, stall_req}, 32'd1);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("lb_c3_stall", {31'd0, stall_req}, 32'd0);
        chk("lb_wdata",    mem_wdata,          32'hFFFF_FF80);
        chk("lb_wreg",     {31'd0, mem_wreg},  32'd1);
        chk("lb_wd",       {27'd0, mem_wd},    32'd3);
        chk("lb_c3_req",   {31'd0, dbus_req},  32'd0);
        next_cycle();

        // LBU at 0x1000 picks the most significant byte, k=1
        set_op(MOP_LBU, 32'h0000_1000, 32'd0, 5'd6);
        next_cycle();
        dbus_ack = 1'b1; dbus_rdata = 32'h9A12_3456;
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("lbu_wdata", mem_wdata, 32'h0000_009A);
        next_cycle();

        // SH at 0x2002
        set_op(MOP_SH, 32'h0000_2002, 32'h0000_ABCD, 5'd7);
        @(negedge clk);
        chk("sh_c0_wreg", {31'd0, mem_wreg}, 32'd0);
        next_cycle();
        dbus_ack = 1'b1;
        @(negedge clk);
        chk("sh_be",    {28'd0, dbus_be}, 32'h3);
        chk("sh_wdata", dbus_wdata,       32'hABCD_ABCD);
        chk("sh_we",    {31'd0, dbus_we}, 32'd1);
        chk("sh_addr",  dbus_addr,        32'h0000_2000);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("sh_done_wreg",  {31'd0, mem_wreg},  32'd0);
        chk("sh_done_stall", {31'd0, stall_req}, 32'd0);
        next_cycle();
        go_idle();

        // Misaligned LW
        set_op(MOP_LW, 32'h0000_3001, 32'd0, 5'd2);
        @(negedge clk);
        chk("mis_req",   {31'd0, dbus_req},  32'd0);
        chk("mis_stall", {31'd0, stall_req}, 32'd0);
        chk("mis_exc",   mem_excepttype,     32'h10);
        chk("mis_badv",  mem_badvaddr,       32'h0000_3001);
        chk("mis_wreg",  {31'd0, mem_wreg},  32'd0);
        next_cycle();
        @(negedge clk);
        chk("mis_req2", {31'd0, dbus_req}, 32'd0);
        next_cycle();

        // LL at 0x40
        set_op(MOP_LL, 32'h0000_0040, 32'd0, 5'd8);
        next_cycle();
        dbus_ack = 1'b1; dbus_rdata = 32'hCAFE_F00D;
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("ll_wdata",    mem_wdata,               32'hCAFE_F00D);
        chk("ll_wreg_ll",  {31'd0, mem_wreg_LLbit}, 32'd1);
        chk("ll_wdata_ll", {31'd0, mem_wdata_LLbit}, 32'd1);
        chk("ll_badv",     mem_badvaddr,            32'd0);
        next_cycle();

        // SC succeeding
        set_op(MOP_SC, 32'h0000_0040, 32'h0000_0055, 5'd8);
        llbit_i = 1'b1;
        @(negedge clk);
        chk("sc1_stall", {31'd0, stall_req}, 32'd1);
        next_cycle();
        dbus_ack = 1'b1;
        @(negedge clk);
        chk("sc1_we",    {31'd0, dbus_we},  32'd1);
        chk("sc1_be",    {28'd0, dbus_be},  32'hF);
        chk("sc1_bdata", dbus_wdata,        32'h0000_0055);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("sc1_wdata",    mem_wdata,                32'd1);
        chk("sc1_wreg",     {31'd0, mem_wreg},        32'd1);
        chk("sc1_wreg_ll",  {31'd0, mem_wreg_LLbit},  32'd1);
        chk("sc1_wdata_ll", {31'd0, mem_wdata_LLbit}, 32'd0);
        next_cycle();

        // SC failing: no bus cycle
        llbit_i = 1'b0;
        @(negedge clk);
        chk("sc0_req",     {31'd0, dbus_req},       32'd0);
        chk("sc0_stall",   {31'd0, stall_req},      32'd0);
        chk("sc0_wreg",    {31'd0, mem_wreg},       32'd1);
        chk("sc0_wdata",   mem_wdata,               32'd0);
        chk("sc0_wreg_ll", {31'd0, mem_wreg_LLbit}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("sc0_req2", {31'd0, dbus_req}, 32'd0);
        next_cycle();

        // Flush in first REQ cycle, ack three cycles later
        set_op(MOP_LW, 32'h0000_0050, 32'd0, 5'd9);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_c1_req",  {31'd0, dbus_req}, 32'd1);
        chk("fl_c1_wreg", {31'd0, mem_wreg}, 32'd0);
        next_cycle();
        flush = 1'b0; ex_mem_op = MOP_NONE; ex_addr = 32'h9999_0000; ex_wreg = 1'b1;
        @(negedge clk);
        chk("fl_c2_req",   {31'd0, dbus_req},  32'd1);
        chk("fl_c2_addr",  dbus_addr,          32'h0000_0050);
        chk("fl_c2_stall", {31'd0, stall_req}, 32'd1);
        chk("fl_c2_wreg",  {31'd0, mem_wreg},  32'd0);
        next_cycle();
        @(negedge clk);
        chk("fl_c3_req", {31'd0, dbus_req}, 32'd1);
        next_cycle();
        dbus_ack = 1'b1;
        @(negedge clk);
        chk("fl_c4_req",  {31'd0, dbus_req}, 32'd1);
        chk("fl_c4_wreg", {31'd0, mem_wreg}, 32'd0);
        next_cycle();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("fl_c5_req",   {31'd0, dbus_req},  32'd0);
        chk("fl_c5_stall", {31'd0, stall_req}, 32'd0);
        chk("fl_c5_wreg",  {31'd0, mem_wreg},  32'd1);
        next_cycle();

        // Bus error: err without ack ignored, then err with ack
        set_op(MOP_LW, 32'h0000_0060, 32'd0, 5'd2);
        next_cycle();
        dbus_err = 1'b1;
        @(negedge clk);
        chk("be_noack_req", {31'd0, dbus_req}, 32'd1);
        next_cycle();
        dbus_ack = 1'b1; dbus_rdata = 32'h1234_5678;
        next_cycle();
        dbus_ack = 1'b0; dbus_err = 1'b0;
        @(negedge clk);
        chk("be_exc",  mem_excepttype,    32'h80);
        chk("be_wreg", {31'd0, mem_wreg}, 32'd0);
        chk("be_badv", mem_badvaddr,      32'h0000_0060);
        next_cycle();

        // Reset asserted mid-transaction
        set_op(MOP_LW, 32'h0000_0070, 32'd0, 5'd2);
        next_cycle();
        @(negedge clk);
        chk("rm_req_before", {31'd0, dbus_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rm_req_during",   {31'd0, dbus_req},  32'd0);
        chk("rm_stall_during", {31'd0, stall_req}, 32'd0);
        go_idle();
        #1 rst = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("rm_req_after", {31'd0, dbus_req}, 32'd0);
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
